weight_mem_loader: RTL



---
 rtl/weight_mem_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/weight_mem_loader.sv
// ==========================================================================
// weight_mem_loader - streams host weights into one layer's neuron memories
// Optional macro WEIGHT_LOAD_CHECKSUM_EN adds a 32-bit checksum. Rev 1.0
// ==========================================================================
`default_nettype none

module weight_mem_loader #(
  parameter int numNeurons   = 30,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [dataWidth-1:0]    s_data,
  output logic                    s_ready,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth:0]   waddr,
  output logic [dataWidth-1:0]    wdata,
  output logic                    busy,
  output logic                    done
`ifdef WEIGHT_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]             checksum
`endif
);

  localparam int NCW = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [addressWidth:0] LAST_ADDR   = (addressWidth + 1)'(numWeight - 1);
  localparam logic [NCW-1:0]        LAST_NEURON = NCW'(numNeurons - 1);

  logic [1:0]              state;
  logic [NCW-1:0]          neuron_cnt;
  logic [addressWidth:0]   addr_cnt;
  logic                    accept;
  logic                    last_addr;
  logic                    last_neuron;

  assign s_ready     = (state == ST_LOAD);
  assign busy        = (state != ST_IDLE);
  assign accept      = s_valid && s_ready;
  assign last_addr   = (addr_cnt == LAST_ADDR);
  assign last_neuron = (neuron_cnt == LAST_NEURON);

  // Control path: state and the neuron/address walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      neuron_cnt <= '0;
      addr_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            neuron_cnt <= '0;
            addr_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (last_addr) begin
              addr_cnt <= '0;
              // Completion replaces the neuron wrap on the final beat.
              if (last_neuron) begin
                state <= ST_DRAIN;
              end else begin
                neuron_cnt <= neuron_cnt + NCW'(1);
              end
            end else begin
              addr_cnt <= addr_cnt + (addressWidth + 1)'(1);
            end
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write port: one registered write per accepted beat, strobe idle otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen   <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      if (accept) begin
        wen   <= numNeurons'(1) << neuron_cnt;
        waddr <= addr_cnt;
        wdata <= s_data;
      end else begin
        wen   <= '0;
      end
    end
  end

`ifdef WEIGHT_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        checksum <= '0;
      end else if (accept) begin
        checksum <= checksum + 32'($signed(s_data));
      end
    end
  end
`endif

endmodule

`default_nettype wire
